// File: rtl/fetch_resp.sv
// Instruction-fetch responder: issues fixed-latency reads of a preloadable instruction memory,
// buffers results in a small FIFO for decode, and returns credit-based backpressure to fetch.
module fetch_resp #(
    parameter int MEM_DEPTH   = 1024,
    parameter int FIFO_DEPTH  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        stall_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        instr_ready,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NS = MEM_LATENCY - 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [29:0] MEM_WORDS = 30'(MEM_DEPTH);
    localparam logic [CW-1:0] FULL_CREDIT = CW'(FIFO_DEPTH);

    logic [31:0]   mem_r [MEM_DEPTH];
    logic [31:0]   fifo_data_r [FIFO_DEPTH];
    logic [31:0]   fifo_pc_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_fault_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] credit_r;

    logic          req_s;
    logic          fault_s;
    logic [31:0]   rdata_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   exit_pc_s;
    logic [31:0]   exit_data_s;
    logic          exit_fault_s;
    logic          unused_s;

    assign unused_s = ^{imem_waddr[31:AW+2], imem_waddr[1:0]};

    // Credit covers every issued-but-unpopped fetch, so a full credit means the FIFO cannot take more.
    assign stall_pc = (credit_r == FULL_CREDIT) && !flush;
    assign req_s    = !i_rst && !flush && !stall_pc;
    assign fault_s  = (pc[1:0] != 2'b00) || (pc[31:2] >= MEM_WORDS);
    assign rdata_s  = fault_s ? NOP_INSTR : mem_r[pc[AW+1:2]];

    // Preload write port; the read above sees the pre-edge contents.
    always_ff @(posedge i_clk) begin
        if (imem_we) begin
            mem_r[imem_waddr[AW+1:2]] <= imem_wdata;
        end
    end

    // The issue cycle counts as the first latency cycle; remaining cycles are register stages.
    generate
        if (NS == 0) begin : g_nopipe
            assign push_s       = req_s;
            assign exit_pc_s    = pc;
            assign exit_data_s  = rdata_s;
            assign exit_fault_s = fault_s;
        end else begin : g_pipe
            logic [NS-1:0] v_r;
            logic [NS-1:0] f_r;
            logic [31:0]   pc_r [NS];
            logic [31:0]   data_r [NS];

            // Valid bits of the latency shift pipeline; cleared on reset and redirect.
            always_ff @(posedge i_clk) begin
                if (i_rst || flush) begin
                    v_r <= '0;
                end else begin
                    v_r[0] <= req_s;
                    for (int i = 1; i < NS; i++) begin
                        v_r[i] <= v_r[i-1];
                    end
                end
            end

            // Payload of the latency shift pipeline.
            always_ff @(posedge i_clk) begin
                pc_r[0]   <= pc;
                data_r[0] <= rdata_s;
                f_r[0]    <= fault_s;
                for (int i = 1; i < NS; i++) begin
                    pc_r[i]   <= pc_r[i-1];
                    data_r[i] <= data_r[i-1];
                    f_r[i]    <= f_r[i-1];
                end
            end

            assign push_s       = v_r[NS-1];
            assign exit_pc_s    = pc_r[NS-1];
            assign exit_data_s  = data_r[NS-1];
            assign exit_fault_s = f_r[NS-1];
        end
    endgenerate

    assign instr_valid = (count_r != {CW{1'b0}});
    assign pop_s       = instr_valid && instr_ready;
    assign instr       = instr_valid ? fifo_data_r[rd_ptr_r] : 32'h0000_0000;
    assign instr_pc    = instr_valid ? fifo_pc_r[rd_ptr_r]   : 32'h0000_0000;
    assign instr_fault = instr_valid ? fifo_fault_r[rd_ptr_r] : 1'b0;

    // FIFO pointers and occupancy; redirect wins over any simultaneous push or pop.
    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // FIFO entry storage.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r]  <= exit_data_s;
            fifo_pc_r[wr_ptr_r]    <= exit_pc_s;
            fifo_fault_r[wr_ptr_r] <= exit_fault_s;
        end
    end

    // Outstanding-fetch credit counter.
    always_ff @(posedge i_clk) begin
        if (i_rst || flush) begin
            credit_r <= '0;
        end else begin
            credit_r <= credit_r + CW'(req_s) - CW'(pop_s);
        end
    end

    fetch_resp_chk #(.FIFO_DEPTH(FIFO_DEPTH)) u_chk (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .flush    (flush),
        .push     (push_s),
        .pop      (pop_s),
        .count    (count_r),
        .credit   (credit_r)
    );

endmodule

// Protocol checker: the FIFO must never overflow and credit must cover its occupancy.
module fetch_resp_chk #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                          i_clk,
    input logic                          i_rst,
    input logic                          flush,
    input logic                          push,
    input logic                          pop,
    input logic [$clog2(FIFO_DEPTH):0]   count,
    input logic [$clog2(FIFO_DEPTH):0]   credit
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst || flush)
        !(push && !pop && (count == CW'(FIFO_DEPTH))));

    a_credit_covers: assert property (@(posedge i_clk) disable iff (i_rst)
        (credit >= count) && (credit <= CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_resp.sv
// Directed bench for fetch_resp: preload, streaming, backpressure, flush, faults, reset, write/read race.
module tb_fetch_resp;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] pc;
    logic        flush;
    logic        stall_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    int checks = 0;
    int errors = 0;

    fetch_resp dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .pc          (pc),
        .flush       (flush),
        .stall_pc    (stall_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault),
        .instr_ready (instr_ready),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst       = 1'b1;
        pc          = 32'd0;
        flush       = 1'b0;
        instr_ready = 1'b1;
        imem_we     = 1'b0;
        imem_waddr  = 32'd0;
        imem_wdata  = 32'd0;

        // Preload words 0..8 while held in reset (memory writes ignore reset).
        for (int i = 0; i < 9; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 32'(i * 4);
            imem_wdata = 32'h1000_0000 + 32'(i);
            tick();
        end
        imem_we = 1'b0;
        i_rst   = 1'b0;

        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_fault", {31'd0, instr_fault}, 32'd0);
        check("rst_stall", {31'd0, stall_pc}, 32'd0);

        // Test 1: streaming with decode always ready.
        for (int c = 0; c < 10; c++) begin
            pc = 32'(4 * c);
            check("t1_stall", {31'd0, stall_pc}, 32'd0);
            if (c >= 2) begin
                check("t1_valid", {31'd0, instr_valid}, 32'd1);
                check("t1_pc", instr_pc, 32'(4 * (c - 2)));
                check("t1_instr", instr, 32'h1000_0000 + 32'(c - 2));
            end else begin
                check("t1_valid0", {31'd0, instr_valid}, 32'd0);
            end
            tick();
        end

        // Test 2: backpressure, stall after four requests, release one cycle after first pop.
        do_reset();
        instr_ready = 1'b0;
        for (int c = 0; c < 11; c++) begin
            pc = (c < 4) ? 32'(4 * c) : ((c < 8) ? 32'd16 : 32'd20);
            instr_ready = (c >= 6);
            check("t2_stall", {31'd0, stall_pc}, (c >= 4 && c <= 6) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check("t2_valid", {31'd0, instr_valid}, 32'd1);
                check("t2_pc", instr_pc, (c <= 6) ? 32'd0 : 32'(4 * (c - 6)));
                check("t2_instr", instr, 32'h1000_0000 + ((c <= 6) ? 32'd0 : 32'(c - 6)));
            end
            tick();
        end

        // Test 5: fill and stall, check flush forces stall low, then reset mid-operation.
        do_reset();
        instr_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            pc = (c < 4) ? 32'(4 * c) : 32'd16;
            tick();
        end
        check("t5_full_stall", {31'd0, stall_pc}, 32'd1);
        check("t5_full_head", instr_pc, 32'd0);
        flush = 1'b1;
        #1;
        check("t5_flush_stall", {31'd0, stall_pc}, 32'd0);
        flush = 1'b0;
        #1;
        check("t5_stall_back", {31'd0, stall_pc}, 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        pc = 32'd0;
        instr_ready = 1'b1;
        check("t5_valid0", {31'd0, instr_valid}, 32'd0);
        check("t5_stall0", {31'd0, stall_pc}, 32'd0);
        check("t5_instr0", instr, 32'd0);
        tick();
        check("t5_nostale", {31'd0, instr_valid}, 32'd0);
        tick();
        check("t5_valid", {31'd0, instr_valid}, 32'd1);
        check("t5_pc", instr_pc, 32'd0);
        check("t5_instr", instr, 32'h1000_0000);

        // Test 3: flush with two buffered entries and one in flight, redirect to pc=32.
        do_reset();
        instr_ready = 1'b0;
        pc = 32'd0;  tick();
        pc = 32'd4;  tick();
        pc = 32'd8;  tick();
        check("t3_pre_head", instr_pc, 32'd0);
        flush = 1'b1;
        pc = 32'd32;
        check("t3_flush_stall", {31'd0, stall_pc}, 32'd0);
        tick();
        flush = 1'b0;
        check("t3_empty1", {31'd0, instr_valid}, 32'd0);
        tick();
        pc = 32'd36;
        check("t3_empty2", {31'd0, instr_valid}, 32'd0);
        tick();
        check("t3_valid", {31'd0, instr_valid}, 32'd1);
        check("t3_pc", instr_pc, 32'd32);
        check("t3_instr", instr, 32'h1000_0008);
        tick();
        check("t3_hold_pc", instr_pc, 32'd32);
        check("t3_hold_instr", instr, 32'h1000_0008);

        // Test 4: misaligned and out-of-range fetches return faulted NOPs in order.
        do_reset();
        instr_ready = 1'b1;
        pc = 32'd6;    tick();
        pc = 32'd4096; tick();
        pc = 32'd0;
        check("t4_pc_a", instr_pc, 32'd6);
        check("t4_instr_a", instr, 32'h0000_0013);
        check("t4_fault_a", {31'd0, instr_fault}, 32'd1);
        tick();
        check("t4_pc_b", instr_pc, 32'd4096);
        check("t4_instr_b", instr, 32'h0000_0013);
        check("t4_fault_b", {31'd0, instr_fault}, 32'd1);
        tick();
        check("t4_pc_c", instr_pc, 32'd0);
        check("t4_instr_c", instr, 32'h1000_0000);
        check("t4_fault_c", {31'd0, instr_fault}, 32'd0);

        // Test 6: same-cycle write/read returns old data, next request sees new data.
        do_reset();
        instr_ready = 1'b1;
        pc         = 32'd12;
        imem_we    = 1'b1;
        imem_waddr = 32'd12;
        imem_wdata = 32'hDEAD_BEEF;
        tick();
        imem_we = 1'b0;
        tick();
        check("t6_old_pc", instr_pc, 32'd12);
        check("t6_old", instr, 32'h1000_0003);
        tick();
        check("t6_new_pc", instr_pc, 32'd12);
        check("t6_new", instr, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_resp.md
Name: fetch_resp

Overview:
- Instruction-fetch responder sitting at the far end of the PC interface driven by the fetch unit.
- Consumes the PC stream, reads instruction memory with fixed latency and buffers returned instructions in a small FIFO for decode.
- Drives `stall_pc` back to the fetch unit as credit-based backpressure.
- Discards all in-flight and buffered fetches on a redirect (flush).

Parameters:
- MEM_DEPTH, 1024, instruction memory size in 32-bit words (power of 2).
- FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2).
- MEM_LATENCY, 2, cycles from request to earliest `instr_valid` (>=1).

Ports:
- i_clk  in  1  clock, all logic on posedge.
- i_rst  in  1  reset, synchronous, active-high.
- pc  in  32  fetch address presented by the fetch unit.
- flush  in  1  redirect; asserted in the same cycle the fetch unit loads a new PC.
- stall_pc  out  1  hold PC (to fetch unit).
- instr_valid  out  1  FIFO head valid.
- instr  out  32  FIFO head instruction.
- instr_pc  out  32  PC of FIFO head.
- instr_fault  out  1  FIFO head fetch was misaligned or out of range.
- instr_ready  in  1  decode accepts head.
- imem_we  in  1  memory preload write enable.
- imem_waddr  in  32  preload byte address; word index = `imem_waddr[31:2]` mod MEM_DEPTH.
- imem_wdata  in  32  preload data.

Behaviour:
- **Reset** (`i_rst`=1 at posedge):
  - FIFO emptied; all pipeline valid bits cleared; credit count = 0.
  - Outputs `instr_valid`=0, `instr`=0, `instr_pc`=0, `instr_fault`=0.
  - `stall_pc`=0 from the cycle after reset.
  - Memory contents are not cleared.
  - Reset mid-operation drops everything in flight; no stale entry may appear afterwards.
- **Request issue:**
  - One request per cycle where `i_rst`=0, `flush`=0 and `stall_pc`=0; address = `pc` sampled that cycle.
  - Memory read uses `pc[31:2]`.
  - Fault when `pc[1:0]`!=0 or `pc[31:2]`>=MEM_DEPTH. A faulted entry carries `instr`=32'h00000013 (NOP) and `instr_fault`=1.
- **Latency pipeline:**
  - Shift pipeline of depth MEM_LATENCY carrying {valid, pc, data, fault}.
  - A request issued in cycle t with an empty FIFO shows `instr_valid`=1 in cycle t+MEM_LATENCY.
  - Back-to-back requests return back-to-back, in order.
- **FIFO:**
  - Push from pipeline exit; pop when `instr_valid`&&`instr_ready`.
  - Push and pop in the same cycle are both allowed.
  - Head outputs are registered/stable while `instr_valid`=1 and `instr_ready`=0.
- **Credit / stall:**
  - `credit` = FIFO occupancy + valid pipeline entries (registered, width clog2(FIFO_DEPTH)+1).
  - `stall_pc` = (`credit`==FIFO_DEPTH) && !`flush`. This is combinational from registered state.
  - A pop in cycle c lowers `stall_pc` in cycle c+1, not c.
  - The FIFO can never overflow; an overflow is an assertion failure.
- **Flush:**
  - In a cycle with `flush`=1: no request is issued, all pipeline valids clear, the FIFO empties, and `credit`=0 at the next edge.
  - Flush overrides a simultaneous push/pop. A pop in the flush cycle is still considered consumed by decode.
  - `stall_pc` is forced 0 during flush so the fetch unit's redirect is taken.
  - The first post-flush request is the redirected PC in the following cycle.
- **Memory writes:**
  - `imem_we` writes on posedge.
  - A same-cycle read of the same word returns the old data.
  - Writes are independent of reset and flush.

Test Plan:
1. Preload words 0..7 = 32'h1000_0000+i; `pc` sequence 0,4,8,... with `instr_ready`=1 -> `instr_valid` first in cycle 2 with `instr`=32'h10000000/`instr_pc`=0, then one instruction per cycle in order; `stall_pc` never asserts.
2. Same preload, `instr_ready`=0 -> `stall_pc` rises after exactly 4 requests (pc 0,4,8,12); pc held at 16; raise `instr_ready` -> heads 0,4,8,12 pop in order and `stall_pc` drops one cycle after the first pop.
3. FIFO holding pc 0,4 plus one in flight; assert `flush` with the fetch unit redirecting to pc=32 -> next cycle `instr_valid`=0; 2 cycles later head `instr_pc`=32, `instr`=32'h10000008 when word 8 is preloaded to that value; nothing from 0,4,8 ever appears.
4. Request `pc`=6 and then `pc`=MEM_DEPTH*4 -> both return `instr`=32'h00000013 with `instr_fault`=1, in order, normal latency.
5. `i_rst`=1 for one cycle while FIFO is full and stalled -> following cycle `instr_valid`=0 and `stall_pc`=0; a new request at pc=0 returns correctly 2 cycles later.
6. Write word 3 = 32'hDEADBEEF via the preload port in the same cycle `pc`=12 is requested -> old value returned; a re-request next cycle returns 32'hDEADBEEF.
